// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon Says sequence player.
package simon_pkg;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        GREEN  = 2'd1,
        BLUE   = 2'd2,
        YELLOW = 2'd3
    } color_t;

    typedef enum logic [1:0] {
        IDLE,
        SHOW_ON,
        SHOW_OFF,
        LISTEN
    } seq_state_t;

    localparam logic [3:0] LED_OFF = 4'b0000;

    function automatic logic [3:0] color_led(input color_t c);
        return 4'b0001 << c;
    endfunction

endpackage

// File: rtl/seq_mem.sv
// Colour sequence register file: one synchronous write port, one asynchronous
// read port so playback and press comparison see the entry in the same cycle.
module seq_mem #(
    parameter int DEPTH = 32,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [1:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [1:0]    rdata
);

    logic [1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/simon_seq_player.sv
// Records rng colours, replays them on the LEDs with fixed on/off timing, then
// checks the player's presses against the stored sequence.
module simon_seq_player
    import simon_pkg::*;
#(
    parameter int MAX_LEN    = 32,
    parameter int ON_CYCLES  = 25_000_000,
    parameter int OFF_CYCLES = 12_500_000,
    localparam int LW        = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          append,
    input  logic [1:0]    rng_num,
    input  logic          play,
    input  logic          btn_valid,
    input  logic [1:0]    btn_color,
    output logic [3:0]    led,
    output logic          busy,
    output logic          play_done,
    output logic          press_ok,
    output logic          press_fail,
    output logic          round_done,
    output logic [LW-1:0] seq_len,
    output logic          full
);

    localparam int IW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int MAXC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LAST = TW'(OFF_CYCLES - 1);
    localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN);

    seq_state_t    state;
    logic [LW-1:0] len;
    logic [IW-1:0] idx;
    logic [IW-1:0] rd_idx;
    logic [IW-1:0] last_idx;
    logic [TW-1:0] tmr;
    logic [1:0]    cur_color;
    logic          at_last;
    logic          wr_en;

    assign last_idx = IW'(len - LW'(1));
    assign at_last  = (idx == last_idx);
    assign wr_en    = (state == IDLE) && append && !full && !clear;
    assign seq_len  = len;

    // The LED register is loaded one cycle ahead of the entry it shows, so the
    // read address looks ahead: entry 0 from IDLE, idx+1 from the dark gap.
    always_comb begin
        rd_idx = idx;
        if (state == IDLE) begin
            rd_idx = '0;
        end else if (state == SHOW_OFF && !at_last) begin
            rd_idx = idx + IW'(1);
        end
    end

    seq_mem #(
        .DEPTH (MAX_LEN),
        .AW    (IW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (len[IW-1:0]),
        .wdata (rng_num),
        .raddr (rd_idx),
        .rdata (cur_color)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            len        <= '0;
            idx        <= '0;
            tmr        <= '0;
            led        <= LED_OFF;
            busy       <= 1'b0;
            full       <= 1'b0;
            play_done  <= 1'b0;
            press_ok   <= 1'b0;
            press_fail <= 1'b0;
            round_done <= 1'b0;
        end else begin
            play_done  <= 1'b0;
            press_ok   <= 1'b0;
            press_fail <= 1'b0;
            round_done <= 1'b0;
            if (clear) begin
                state <= IDLE;
                len   <= '0;
                idx   <= '0;
                tmr   <= '0;
                led   <= LED_OFF;
                busy  <= 1'b0;
                full  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (append) begin
                            if (!full) begin
                                len  <= len + LW'(1);
                                full <= (len + LW'(1) == LEN_MAX);
                            end
                        end else if (play) begin
                            if (len == '0) begin
                                play_done <= 1'b1;
                            end else begin
                                state <= SHOW_ON;
                                idx   <= '0;
                                tmr   <= '0;
                                led   <= color_led(color_t'(cur_color));
                                busy  <= 1'b1;
                            end
                        end
                    end
                    SHOW_ON: begin
                        if (tmr == ON_LAST) begin
                            state <= SHOW_OFF;
                            tmr   <= '0;
                            led   <= LED_OFF;
                        end else begin
                            tmr <= tmr + TW'(1);
                        end
                    end
                    SHOW_OFF: begin
                        if (tmr == OFF_LAST) begin
                            tmr <= '0;
                            if (at_last) begin
                                play_done <= 1'b1;
                                state     <= LISTEN;
                                idx       <= '0;
                            end else begin
                                idx   <= idx + IW'(1);
                                state <= SHOW_ON;
                                led   <= color_led(color_t'(cur_color));
                            end
                        end else begin
                            tmr <= tmr + TW'(1);
                        end
                    end
                    LISTEN: begin
                        if (btn_valid) begin
                            if (btn_color == cur_color) begin
                                press_ok <= 1'b1;
                                if (at_last) begin
                                    round_done <= 1'b1;
                                    state      <= IDLE;
                                    busy       <= 1'b0;
                                end else begin
                                    idx <= idx + IW'(1);
                                end
                            end else begin
                                press_fail <= 1'b1;
                                state      <= IDLE;
                                busy       <= 1'b0;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_simon_seq_player.sv
// Scoreboard bench for simon_seq_player: expected LED/pulse events are queued
// with their cycle stamp at stimulus time and popped by a negedge monitor.
module tb_simon_seq_player;

    logic       clk;
    logic       reset;
    logic       clear;
    logic       append;
    logic [1:0] rng_num;
    logic       play;
    logic       btn_valid;
    logic [1:0] btn_color;
    logic [3:0] led;
    logic       busy;
    logic       play_done;
    logic       press_ok;
    logic       press_fail;
    logic       round_done;
    logic [2:0] seq_len;
    logic       full;

    simon_seq_player #(
        .MAX_LEN    (4),
        .ON_CYCLES  (3),
        .OFF_CYCLES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .append     (append),
        .rng_num    (rng_num),
        .play       (play),
        .btn_valid  (btn_valid),
        .btn_color  (btn_color),
        .led        (led),
        .busy       (busy),
        .play_done  (play_done),
        .press_ok   (press_ok),
        .press_fail (press_fail),
        .round_done (round_done),
        .seq_len    (seq_len),
        .full       (full)
    );

    typedef struct {
        int         cyc;
        logic [3:0] led;
        logic       pd;
        logic       ok;
        logic       fail;
        logic       rd;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc      = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end else begin
            $display("ok   %s: %0h (cycle %0d)", name, act, cyc);
        end
    endtask

    task automatic push_ev(input int at, input logic [3:0] l, input logic pd,
                           input logic ok, input logic fl, input logic rd);
        ev_t e;
        e.cyc = at; e.led = l; e.pd = pd; e.ok = ok; e.fail = fl; e.rd = rd;
        exp_q.push_back(e);
    endtask

    // Monitor: any LED change or result pulse is one DUT event.
    initial begin
        logic [3:0] prev;
        prev = 4'b0000;
        forever begin
            @(negedge clk);
            if (led !== prev || play_done || press_ok || press_fail || round_done) begin
                ev_t a;
                ev_t e;
                a.cyc = cyc; a.led = led; a.pd = play_done;
                a.ok = press_ok; a.fail = press_fail; a.rd = round_done;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event: got cyc=%0d led=%b pd=%b ok=%b fail=%b rd=%b, required none",
                             a.cyc, a.led, a.pd, a.ok, a.fail, a.rd);
                end else begin
                    e = exp_q.pop_front();
                    if (a.cyc != e.cyc || a.led !== e.led || a.pd !== e.pd ||
                        a.ok !== e.ok || a.fail !== e.fail || a.rd !== e.rd) begin
                        n_fail++;
                        $display("FAIL event: got cyc=%0d led=%b pd=%b ok=%b fail=%b rd=%b, required cyc=%0d led=%b pd=%b ok=%b fail=%b rd=%b",
                                 a.cyc, a.led, a.pd, a.ok, a.fail, a.rd,
                                 e.cyc, e.led, e.pd, e.ok, e.fail, e.rd);
                    end else begin
                        $display("ok   event: cyc=%0d led=%b pd=%b ok=%b fail=%b rd=%b",
                                 a.cyc, a.led, a.pd, a.ok, a.fail, a.rd);
                    end
                end
            end
            prev = led;
        end
    end

    task automatic do_append(input logic [1:0] v);
        append  = 1'b1;
        rng_num = v;
        step();
        append  = 1'b0;
    endtask

    task automatic do_press(input logic [1:0] v, input logic ok, input logic last);
        push_ev(cyc + 1, 4'b0000, 1'b0, ok, !ok, ok && last);
        btn_valid = 1'b1;
        btn_color = v;
        step();
        btn_valid = 1'b0;
        step();
    endtask

    // Plays the stored 2,0,3 sequence and lands in LISTEN.
    task automatic play_203();
        int c;
        c = cyc;
        push_ev(c + 1,  4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
        push_ev(c + 4,  4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        push_ev(c + 6,  4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
        push_ev(c + 9,  4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        push_ev(c + 11, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0);
        push_ev(c + 14, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        push_ev(c + 16, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        play = 1'b1;
        step();
        play = 1'b0;
        repeat (16) step();
    endtask

    initial begin
        int c;
        reset = 1'b0; clear = 1'b0; append = 1'b0; rng_num = 2'd0;
        play = 1'b0; btn_valid = 1'b0; btn_color = 2'd0;
        #1 reset = 1'b1;
        @(negedge clk);
        check("reset_led", 32'(led), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_seq_len", 32'(seq_len), 32'h0);
        check("reset_full", 32'(full), 32'h0);
        check("reset_pulses", {28'h0, play_done, press_ok, press_fail, round_done}, 32'h0);
        step();
        reset = 1'b0;
        step();

        // 1: record 2,0,3 and replay
        do_append(2'd2);
        do_append(2'd0);
        do_append(2'd3);
        check("seq_len_after_3", 32'(seq_len), 32'd3);
        check("full_after_3", 32'(full), 32'd0);
        play_203();
        check("busy_listen", 32'(busy), 32'd1);

        // 2: correct round
        do_press(2'd2, 1'b1, 1'b0);
        do_press(2'd0, 1'b1, 1'b0);
        do_press(2'd3, 1'b1, 1'b1);
        check("busy_after_round", 32'(busy), 32'd0);

        // 3: wrong second press
        play_203();
        do_press(2'd2, 1'b1, 1'b0);
        do_press(2'd1, 1'b0, 1'b0);
        check("busy_after_fail", 32'(busy), 32'd0);
        check("seq_len_after_fail", 32'(seq_len), 32'd3);

        // 4: fill to MAX_LEN, extra append ignored
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("seq_len_after_clear", 32'(seq_len), 32'd0);
        do_append(2'd0);
        do_append(2'd1);
        do_append(2'd2);
        check("full_after_3_of_4", 32'(full), 32'd0);
        do_append(2'd3);
        check("full_after_4", 32'(full), 32'd1);
        do_append(2'd0);
        check("seq_len_after_5", 32'(seq_len), 32'd4);
        check("full_after_5", 32'(full), 32'd1);

        // 5: clear during SHOW_ON, then play on an empty sequence
        c = cyc;
        push_ev(c + 1, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
        push_ev(c + 3, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        play = 1'b1;
        step();
        play = 1'b0;
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clear_led", 32'(led), 32'h0);
        check("clear_busy", 32'(busy), 32'h0);
        check("clear_seq_len", 32'(seq_len), 32'h0);
        check("clear_full", 32'(full), 32'h0);
        c = cyc;
        push_ev(c + 1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        play = 1'b1;
        step();
        play = 1'b0;
        step();
        step();
        check("empty_play_busy", 32'(busy), 32'h0);

        // 6: reset mid-LISTEN with a press in the same cycle
        do_append(2'd1);
        do_append(2'd2);
        c = cyc;
        push_ev(c + 1,  4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
        push_ev(c + 4,  4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        push_ev(c + 6,  4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
        push_ev(c + 9,  4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        push_ev(c + 11, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        play = 1'b1;
        step();
        play = 1'b0;
        repeat (11) step();
        check("busy_listen2", 32'(busy), 32'd1);
        do_press(2'd1, 1'b1, 1'b0);
        btn_valid = 1'b1;
        btn_color = 2'd2;
        reset     = 1'b1;
        #1;
        check("async_reset_busy", 32'(busy), 32'h0);
        check("async_reset_seq_len", 32'(seq_len), 32'h0);
        step();
        btn_valid = 1'b0;
        step();
        reset = 1'b0;
        check("reset_mid_outputs", {24'h0, led, busy, full, seq_len[1:0]}, 32'h0);
        step();
        do_append(2'd3);
        check("seq_len_post_reset", 32'(seq_len), 32'd1);
        c = cyc;
        push_ev(c + 1, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0);
        push_ev(c + 4, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        push_ev(c + 6, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        play = 1'b1;
        step();
        play = 1'b0;
        repeat (6) step();
        do_press(2'd3, 1'b1, 1'b1);
        repeat (3) step();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/simon_seq_player.md
# simon_seq_player

Sequence store and replayer for the Simon Says game, sitting downstream of the `rng` block. It records each 2-bit colour drawn from `rng`, replays the stored sequence to the four LEDs with fixed on/off timing, and then checks the player's button presses against it. It reports per-press and per-round results to the game FSM.

## Interface
Parameters:
- `MAX_LEN`, 32: maximum sequence length; must be ≥ 1.
- `ON_CYCLES`, 25_000_000: clock cycles each colour LED is lit during playback; must be ≥ 1.
- `OFF_CYCLES`, 12_500_000: clock cycles of dark gap after each colour; must be ≥ 1.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `clear`  in  1  empty the sequence and abort any activity.
- `append`  in  1  push `rng_num` onto the sequence.
- `rng_num`  in  2  colour from `rng.number_out`.
- `play`  in  1  start playback of the stored sequence.
- `btn_valid`  in  1  single-cycle strobe for a debounced player press.
- `btn_color`  in  2  colour of the press.
- `led`  out  4  one-hot LED drive: bit `n` lights colour `n`.
- `busy`  out  1  high in any state other than IDLE.
- `play_done`  out  1  1-cycle pulse when playback finishes.
- `press_ok`  out  1  1-cycle pulse when a press matches.
- `press_fail`  out  1  1-cycle pulse when a press mismatches.
- `round_done`  out  1  1-cycle pulse when the whole sequence has been matched.
- `seq_len`  out  `$clog2(MAX_LEN+1)`  number of stored entries.
- `full`  out  1  `seq_len == MAX_LEN`.

## Operation
States: IDLE, SHOW_ON, SHOW_OFF, LISTEN.

Registered state and counters:
- `len`: number of stored entries.
- `idx`: current position in the sequence.
- `tmr`: phase timer.

Reset:
- State returns to IDLE.
- `len`, `idx`, `tmr` and all outputs clear to 0.
- Memory contents are don't-care.

`clear`:
- Highest priority, accepted in any state.
- Next cycle: IDLE, `len=0`, `idx=0`, `led=0`, no pulses.

IDLE:
- `append` with `!full`: stores `rng_num` at `mem[len]` and increments `len`.
- `append` with `full`: ignored.
- `append` and `play` in the same cycle: the append wins and `play` is ignored.
- `play` with `len==0`: `play_done` pulses next cycle and the state stays IDLE.
- `play` with `len>0`: next state SHOW_ON with `idx=0` and `tmr=0`.

SHOW_ON:
- `led = 1 << mem[idx]`.
- After `ON_CYCLES` cycles, go to SHOW_OFF.

SHOW_OFF:
- `led = 0` for `OFF_CYCLES` cycles.
- Then, if `idx==len-1`: pulse `play_done`, go to LISTEN with `idx=0`.
- Otherwise increment `idx` and go to SHOW_ON.

LISTEN:
- On `btn_valid`, compare `btn_color` with `mem[idx]`.
- Match, not last entry: pulse `press_ok` and increment `idx`.
- Match, last entry: pulse `press_ok` and `round_done` in the same cycle, go to IDLE.
- Mismatch: pulse `press_fail`, go to IDLE.

Inputs ignored outside their states:
- `append` and `play` outside IDLE.
- `btn_valid` outside LISTEN.

## Timing
- All outputs are registered.
- Result pulses (`press_ok`, `press_fail`, `round_done`) appear exactly 1 cycle after the `btn_valid` cycle.
- `seq_len` and `full` update 1 cycle after an accepted `append`.
- Playback latency:
  - `led` goes non-zero 1 cycle after `play` is sampled.
  - Each entry occupies exactly `ON_CYCLES + OFF_CYCLES` cycles.
  - `play_done` asserts on the cycle following the last dark cycle.
  - Total: `play_done` comes `1 + len*(ON_CYCLES+OFF_CYCLES)` cycles after `play`.
- LED waveform: `led` is one-hot or zero, never multi-hot.
- `tmr` width is sized from `max(ON_CYCLES, OFF_CYCLES)`; `tmr` resets to 0 on every phase change.
- Reset mid-playback or mid-listen: outputs go to 0 immediately (asynchronous), no pulse is emitted, and the sequence is lost.

## Structure
- Package `simon_pkg`:
  - `color_t` enum (RED=0, GREEN=1, BLUE=2, YELLOW=3).
  - `seq_state_t` enum for the four states.
  - Shared `LED_OFF` constant.
- Sub-module `seq_mem`: `MAX_LEN` × 2-bit register file with one synchronous write port and one asynchronous read port indexed by `idx`, so the playback/compare read has no extra latency.
- Top level contains the FSM, timer and `len`/`idx` counters.

## Test plan
Bench parameters: `MAX_LEN=4`, `ON_CYCLES=3`, `OFF_CYCLES=2`.

1. Append 2, 0, 3, then `play` → `led` = 0100 ×3, 0000 ×2, 0001 ×3, 0000 ×2, 1000 ×3, 0000 ×2; then `play_done` at cycle 16 after `play`.
2. After scenario 1, press 2, 0, 3 → `press_ok` ×3; `round_done` coincides with the third `press_ok`; `busy` drops.
3. After playback, press 2 then 1 → `press_ok`, then `press_fail` 1 cycle after the second press; state returns to IDLE; `seq_len` is still 3.
4. Append 5 values → `full=1` after the 4th append; the 5th is ignored; `seq_len=4`.
5. Assert `clear` during SHOW_ON → next cycle `led=0`, `busy=0`, `seq_len=0`; `play` then yields `play_done` 1 cycle later with no LED activity.
6. Assert `reset` mid-LISTEN, with `btn_valid` in the same cycle → no pulses; all outputs 0; `append`/`play` work normally after release.
